uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the UART peripheral's single TX FIFO push port among N on-chip byte-stream requesters, such as the CPU console path, a debug tracer and a DMA message engine. Arbitration is packet-locked: a winning requester keeps the port until it delivers a byte flagged `last`, so messages never interleave on the serial line. A stall timeout recovers from a requester that stops mid-packet. The block sits between the requesters and the UART core's `tx_push`/`tx_push_data`/`tx_fifo_full` port.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1024: idle cycles tolerated mid-packet before the grant is revoked; must be ≥ 2.
- `PCLK` in 1: the block's single clock; all logic is rising-edge.
- `PRESETn` in 1: asynchronous, active-low reset.
- `req_valid` in N: requester i has a byte available.
- `req_data` in N*8: byte for requester i, at bits [8i+7:8i].
- `req_last` in N: the byte from requester i ends its packet.
- `req_ready` out N: byte i is accepted this cycle.
- `grant` out N: one-hot owner of the port; all zero when no requester owns it.
- `tx_push` out 1: single-cycle write strobe to the TX FIFO.
- `tx_push_data` out 8: byte written to the TX FIFO.
- `tx_fifo_full` in 1: TX FIFO full flag from the UART core.
- `busy` out 1: high whenever the block is in the XFER state.
- `abort` out 1: one-cycle pulse when a packet is timed out.
- `abort_id` out $clog2(N): index of the requester whose packet was aborted; holds until the next abort.

## Operation
- State machine has two states, IDLE and XFER, plus a round-robin pointer `ptr` of $clog2(N) bits.
- IDLE:
  - `grant` = 0.
  - If any `req_valid` is high, the winner is the first index with `req_valid` set, searching from `ptr` upward and wrapping modulo N.
  - Next cycle: state = XFER, `grant` = one-hot(winner), `ptr` = (winner+1) mod N.
- XFER, with g = the granted index:
  - `req_ready[g]` = `req_valid[g]` & !`tx_fifo_full` & !`tx_push`. All other `req_ready` bits are 0.
  - Accept occurs when `req_valid[g]` & `req_ready[g]`.
  - On accept, in the next cycle: `tx_push` = 1 and `tx_push_data` = `req_data[g]`.
  - If the accepted byte has `req_last[g]` = 1: next state = IDLE and `grant` clears.
- Stall counter (saturating; width $clog2(TIMEOUT+1)):
  - Increments each XFER cycle in which `req_valid[g]` = 0.
  - Clears on accept, in IDLE, and in any cycle where `req_valid[g]` = 1. A stall caused by `tx_fifo_full` therefore never triggers a timeout.
  - When the counter reaches TIMEOUT: next state = IDLE, `abort` pulses, `abort_id` = g. Bytes already pushed stay in the FIFO.
- `tx_push` is never asserted while `tx_fifo_full` was high in the cycle of acceptance. The mandatory gap after each push (the `!tx_push` term) covers the one-cycle lag of the full flag. No byte is ever dropped.
- No preemption. Other requesters' `req_valid` is ignored during XFER. Requester inputs are held while not ready.
- Arbitration is performed only in IDLE. A packet end is therefore followed by one IDLE cycle before the next grant.

## Timing
- Reset (`PRESETn` = 0, asynchronous): state IDLE, `ptr` = 0, stall counter = 0.
  - Outputs: `grant` = 0, `req_ready` = 0, `tx_push` = 0, `tx_push_data` = 0, `busy` = 0, `abort` = 0, `abort_id` = 0.
- Reset asserted mid-packet: an in-flight `tx_push` is cancelled, and a byte registered but not yet pushed is lost.
- Latency: `req_valid` rises in IDLE at cycle t → `grant`/`busy` at t+1 → `req_ready` at t+1 (FIFO not full) → `tx_push` at t+2.
- Throughput: at most one byte every 2 cycles.
- `tx_push` is always exactly 1 cycle wide.
- `req_ready` is combinational from `req_valid`, `tx_fifo_full` and registered state. Every other output is registered.
- Last byte accepted at cycle c: `grant` = 0 at c+1, and a new `grant` no earlier than c+2.
- Timeout: the counter reaches TIMEOUT at cycle c → `abort` high and `grant` = 0 at c+1.

## Test plan
- **Single packet:** requester 2 sends 0x41, 0x42, 0x43 with last on 0x43; FIFO never full → `grant` = 0b0100, pushes 0x41/0x42/0x43 at 2-cycle spacing, then `grant` = 0.
- **Round-robin fairness:** all 4 requesters hold `req_valid` continuously, each with 2-byte packets → grant order 0,1,2,3,0. No byte from one packet appears between the bytes of another.
- **FIFO backpressure:** `tx_fifo_full` held high for 50 cycles mid-packet → `req_ready` = 0 and no `tx_push`; no abort even with TIMEOUT = 16; transfer resumes when full drops, with no lost or duplicated byte.
- **Timeout:** with TIMEOUT = 16, requester 1 sends 1 byte without last, then drops `req_valid` → `abort` pulses 17 cycles after its last accept, `abort_id` = 1, and requester 3 is granted next.
- **Reset mid-packet:** `PRESETn` is pulsed low while `tx_push` = 1 → all outputs 0 immediately, `ptr` = 0, and the next grant goes to the lowest valid index.
- **Boundary:** N = 2, both requesters valid on the same cycle after reset → requester 0 wins first, then requester 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the UART TX FIFO push port among N
// byte-stream requesters, with a mid-packet stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [N-1:0]         req_valid,
  input  logic [N*8-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         grant,
  output logic                 tx_push,
  output logic [7:0]           tx_push_data,
  input  logic                 tx_fifo_full,
  output logic                 busy,
  output logic                 abort,
  output logic [$clog2(N)-1:0] abort_id
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] abort_id_q, abort_id_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_q, push_d;
  logic          abort_q, abort_d;
  logic [7:0]    data_q, data_d;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] idx;
  int unsigned   pos;

  // Next-state, arbitration and combinational ready
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    cnt_d      = '0;
    push_d     = 1'b0;
    data_d     = data_q;
    abort_d    = 1'b0;
    abort_id_d = abort_id_q;
    req_ready  = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    idx        = '0;
    pos        = 0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        // First valid index at or above ptr, wrapping
        for (int unsigned k = 0; k < N; k++) begin
          pos = 32'(ptr_q) + k;
          if (pos >= N) pos = pos - N;
          idx = IW'(pos);
          if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
          end
        end
        if (win_found) begin
          state_d = XFER;
          gidx_d  = win_idx;
          grant_d = N'(1) << win_idx;
          ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
      end

      XFER: begin
        // The !push term covers the one-cycle lag of the full flag
        req_ready[gidx_q] = req_valid[gidx_q] & ~tx_fifo_full & ~push_q;
        if (req_ready[gidx_q]) begin
          push_d = 1'b1;
          data_d = req_data[{gidx_q, 3'b000} +: 8];
          if (req_last[gidx_q]) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!req_valid[gidx_q]) begin
          cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d    = IDLE;
            grant_d    = '0;
            abort_d    = 1'b1;
            abort_id_d = gidx_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      push_q     <= 1'b0;
      data_q     <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      push_q     <= push_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
      abort_id_q <= abort_id_d;
    end
  end

  assign grant        = grant_q;
  assign tx_push      = push_q;
  assign tx_push_data = data_q;
  assign busy         = (state_q == XFER);
  assign abort        = abort_q;
  assign abort_id     = abort_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a 4-requester instance with a short
// timeout plus a 2-requester instance for the same-cycle tie after reset.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic          PCLK;
  logic          PRESETn;
  logic [NR-1:0] req_valid, req_last, req_ready, grant;
  logic [NR*8-1:0] req_data;
  logic          tx_push, tx_fifo_full, busy, abort;
  logic [7:0]    tx_push_data;
  logic [1:0]    abort_id;

  logic [1:0]    v2, l2, rdy2, g2;
  logic [15:0]   d2;
  logic          p2, full2, busy2, abort2;
  logic [7:0]    pd2;
  logic [0:0]    aid2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int push_cnt = 0;
  int last_push_cyc = 0;
  int last_gap = 0;
  int acc_cyc [NR];
  int hd [NR];
  int tl [NR];
  logic [8:0] mem [NR][32];
  logic [7:0] exp_q [$];
  logic [3:0] exp_gnt_q [$];
  logic [7:0] exp2_q [$];
  logic       prev_push;
  logic [3:0] prev_grant;

  uart_tx_arbiter #(.N(NR), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_push(tx_push), .tx_push_data(tx_push_data), .tx_fifo_full(tx_fifo_full),
    .busy(busy), .abort(abort), .abort_id(abort_id)
  );

  uart_tx_arbiter #(.N(2)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(v2), .req_data(d2), .req_last(l2),
    .req_ready(rdy2), .grant(g2),
    .tx_push(p2), .tx_push_data(pd2), .tx_fifo_full(full2),
    .busy(busy2), .abort(abort2), .abort_id(aid2)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < int'(NR); i++) begin
      if (hd[i] != tl[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[8*i +: 8]} = mem[i][hd[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // Queue a packet for requester r and record its bytes and grant as expected
  task automatic add_pkt(input int r, input logic [7:0] base, input int len, input bit has_last);
    for (int k = 0; k < len; k++) begin
      mem[r][tl[r]] = {has_last && (k == len - 1), 8'(base + 8'(k))};
      exp_q.push_back(8'(base + 8'(k)));
      tl[r]++;
    end
    exp_gnt_q.push_back(4'(1) << r);
    drive_reqs();
  endtask

  task automatic flush();
    for (int i = 0; i < int'(NR); i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    exp_q.delete();
    exp_gnt_q.delete();
    push_cnt   = 0;
    prev_push  = 1'b0;
    prev_grant = '0;
    drive_reqs();
  endtask

  task automatic do_reset();
    PRESETn      = 1'b0;
    tx_fifo_full = 1'b0;
    flush();
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
  endtask

  task automatic drain(input string tag, input int limit);
    for (int k = 0; k < limit && exp_q.size() != 0; k++) begin
      @(negedge PCLK);
      #1;
    end
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  // Requester model: a byte leaves its queue when it was valid and ready mid-cycle
  initial begin : driver
    logic [NR-1:0] acc;
    int acyc;
    forever begin
      @(negedge PCLK);
      acc  = req_valid & req_ready;
      acyc = cyc;
      @(posedge PCLK);
      #1;
      if (!PRESETn) acc = '0;
      for (int i = 0; i < int'(NR); i++) begin
        if (acc[i] && hd[i] != tl[i]) begin
          hd[i]++;
          acc_cyc[i] = acyc;
        end
      end
      drive_reqs();
    end
  end

  // Output monitor: pushed bytes and new grants are popped against the scoreboard
  initial begin : monitor
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (tx_push) begin
          check_eq("push_gap", 32'(prev_push), 0);
          last_gap      = cyc - last_push_cyc;
          last_push_cyc = cyc;
          push_cnt++;
          if (exp_q.size() == 0) check_eq("spurious_push", 32'(tx_push), 0);
          else check_eq("push_data", 32'(tx_push_data), 32'(exp_q.pop_front()));
        end
        if (grant != '0 && prev_grant == '0) begin
          check_eq("grant_onehot", 32'($onehot(grant)), 1);
          if (exp_gnt_q.size() == 0) check_eq("spurious_grant", 32'(grant), 0);
          else check_eq("grant_order", 32'(grant), 32'(exp_gnt_q.pop_front()));
        end else if (grant != '0 && grant != prev_grant) begin
          check_eq("grant_switch", 32'(grant), 32'(prev_grant));
        end
        prev_push  = tx_push;
        prev_grant = grant;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

  initial begin : main
    logic [1:0] acc2;
    logic [1:0] first_g2;
    logic seen, seen_rdy, seen_push, seen_abort;
    int lat;

    PRESETn = 1'b0; tx_fifo_full = 1'b0;
    v2 = '0; d2 = '0; l2 = '0; full2 = 1'b0;
    flush();
    repeat (2) @(posedge PCLK);
    #3;
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_push", 32'(tx_push), 0);
    check_eq("rst_data", 32'(tx_push_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_abort", 32'(abort), 0);
    check_eq("rst_abort_id", 32'(abort_id), 0);
    @(posedge PCLK);
    #2 PRESETn = 1'b1;

    // Two requesters valid on the same cycle after reset
    v2 = 2'b11; d2 = 16'hB1A0; l2 = 2'b11; first_g2 = '0;
    exp2_q.push_back(8'hA0);
    exp2_q.push_back(8'hB1);
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      acc2 = v2 & rdy2;
      if (first_g2 == '0) first_g2 = g2;
      if (p2) begin
        if (exp2_q.size() == 0) check_eq("n2_spurious", 32'(p2), 0);
        else check_eq("n2_push", 32'(pd2), 32'(exp2_q.pop_front()));
      end
      @(posedge PCLK);
      #1 v2 = v2 & ~acc2;
    end
    check_eq("n2_first_grant", 32'(first_g2), 32'h1);
    check_eq("n2_drain", 32'(exp2_q.size()), 0);
    check_eq("n2_idle", 32'({busy2, abort2, aid2, g2}), 0);

    // Single packet from requester 2
    do_reset();
    add_pkt(2, 8'h41, 3, 1'b1);
    @(negedge PCLK);
    check_eq("t1_grant_idle", 32'(grant), 0);
    @(negedge PCLK);
    check_eq("t1_grant", 32'(grant), 32'h4);
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_ready", 32'(req_ready), 32'h4);
    @(negedge PCLK);
    check_eq("t1_push_latency", 32'(tx_push), 1);
    drain("t1_drain", 40);
    check_eq("t1_push_spacing", 32'(last_gap), 2);
    check_eq("t1_grant_clear", 32'(grant), 0);
    check_eq("t1_busy_clear", 32'(busy), 0);

    // Round-robin with all requesters continuously valid
    do_reset();
    add_pkt(0, 8'h00, 2, 1'b1);
    add_pkt(1, 8'h10, 2, 1'b1);
    add_pkt(2, 8'h20, 2, 1'b1);
    add_pkt(3, 8'h30, 2, 1'b1);
    add_pkt(0, 8'h08, 2, 1'b1);
    drain("rr_drain", 200);
    check_eq("rr_grants_left", 32'(exp_gnt_q.size()), 0);

    // FIFO full for 50 cycles mid-packet
    do_reset();
    add_pkt(0, 8'h80, 4, 1'b1);
    for (int k = 0; k < 20 && push_cnt == 0; k++) begin
      @(negedge PCLK);
      #1;
    end
    check_eq("bp_first_push", 32'(push_cnt), 1);
    @(posedge PCLK);
    #2 tx_fifo_full = 1'b1;
    seen_rdy = 1'b0; seen_push = 1'b0; seen_abort = 1'b0;
    repeat (50) begin
      @(negedge PCLK);
      seen_rdy   = seen_rdy | (|req_ready);
      seen_push  = seen_push | tx_push;
      seen_abort = seen_abort | abort;
    end
    check_eq("bp_ready", 32'(seen_rdy), 0);
    check_eq("bp_push", 32'(seen_push), 0);
    check_eq("bp_abort", 32'(seen_abort), 0);
    check_eq("bp_grant_hold", 32'(grant), 32'h1);
    @(posedge PCLK);
    #2 tx_fifo_full = 1'b0;
    drain("bp_drain", 40);
    check_eq("bp_count", 32'(push_cnt), 4);

    // Requester 1 stalls mid-packet; requester 3 waiting
    do_reset();
    add_pkt(1, 8'h51, 1, 1'b0);
    add_pkt(3, 8'h53, 1, 1'b1);
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge PCLK);
      #1;
      if (abort) begin
        seen = 1'b1;
        lat  = cyc - acc_cyc[1];
        check_eq("to_grant_clear", 32'(grant), 0);
      end
    end
    check_eq("to_seen", 32'(seen), 1);
    check_eq("to_latency", 32'(lat), 17);
    check_eq("to_abort_id", 32'(abort_id), 1);
    @(negedge PCLK);
    #1 check_eq("to_pulse", 32'(abort), 0);
    drain("to_drain", 40);
    check_eq("to_abort_id_hold", 32'(abort_id), 1);

    // Reset while a push is in flight
    do_reset();
    add_pkt(2, 8'h61, 3, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge PCLK);
      #1 seen = tx_push;
    end
    check_eq("rm_push_seen", 32'(seen), 1);
    PRESETn = 1'b0;
    flush();
    #1;
    check_eq("rm_grant", 32'(grant), 0);
    check_eq("rm_ready", 32'(req_ready), 0);
    check_eq("rm_push", 32'(tx_push), 0);
    check_eq("rm_data", 32'(tx_push_data), 0);
    check_eq("rm_busy", 32'(busy), 0);
    check_eq("rm_abort", 32'(abort), 0);
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    add_pkt(1, 8'h71, 1, 1'b1);
    add_pkt(3, 8'h73, 1, 1'b1);
    drain("rm_drain", 40);
    check_eq("rm_grants_left", 32'(exp_gnt_q.size()), 0);

    repeat (3) @(posedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
